spi_readout_master: RTL
=======================

# spi_readout_master

Serial readout master for the ADC's 12-bit conversion result. Drives `cs_n`/`sclk` toward the slave serial port of `digital_top` and shifts in `serial_data_out` MSB first. Presents the captured word in parallel with a one-cycle valid strobe. Sits on the capture side (FPGA or on-chip host) and is clocked by the same modulator clock `clk` as the ADC.

## Interface
Parameters:
- `WORD_W`, 12: bits per readout word.
- `HALF_PERIOD`, 5: `clk` cycles per `sclk` half-period; must be ≥1.
- `CS_SETUP`, 5: `clk` cycles from `cs_n` fall to the first sample / first `sclk` rise; must be ≥1.
- `CS_HOLD`, 5: `clk` cycles from the last `sclk` fall-phase end to `cs_n` rise; must be ≥1.

All timing parameters must be < 65536; internal counters are 16 bits.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request one readout; sampled only in IDLE.
- `abort` in 1: terminate the transfer in progress.
- `sdi` in 1: slave serial data (`serial_data_out` of the ADC).
- `cs_n` out 1: chip select, active-low, registered.
- `sclk` out 1: serial clock, idles low, registered.
- `data_out` out WORD_W: last completed word.
- `data_valid` out 1: one-cycle pulse when `data_out` updates.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
States: IDLE, SETUP, HIGH, LOW, HOLD.

- **IDLE:** `cs_n`=1, `sclk`=0, `busy`=0. On `start`=1 → SETUP, `cs_n`←0, `cnt`←0, `bit_cnt`←0.
- **SETUP:** counts `CS_SETUP` cycles. On the final count, shift `sdi` into the shift register LSB (left shift), `bit_cnt`++, `sclk`←1 → HIGH.
- **HIGH:** counts `HALF_PERIOD` cycles, then `sclk`←0 → LOW.
- **LOW:** counts `HALF_PERIOD` cycles, then:
  - if `bit_cnt`<`WORD_W`: sample `sdi`, `bit_cnt`++, `sclk`←1 → HIGH;
  - otherwise → HOLD.
- **HOLD:** counts `CS_HOLD` cycles, then `cs_n`←1, `data_out`←shift register, `data_valid`←1 for one cycle → IDLE.
- **Sampling rule:** `sdi` is captured on the same `clk` edge that drives `sclk` high. The slave must hold the bit stable across the preceding low phase and changes it after `sclk` rises. First sampled bit = `data_out[WORD_W-1]`.
- **Start handling:** `start` outside IDLE is ignored and not queued.
- **abort:** with `busy`=1, abort has priority over all transitions. Next edge: `cs_n`←1, `sclk`←0, → IDLE. `data_out` is unchanged and no `data_valid` pulse is issued.
- **Simultaneous `start` and `abort` in IDLE:** `start` wins, because `abort` is only honoured when `busy`=1.
- **Reset, including mid-transfer:** immediately `cs_n`=1, `sclk`=0, `data_out`=0, `data_valid`=0, `busy`=0, state IDLE, counters and shift register 0.

## Timing
Let edge k be the edge at which `start` is accepted. With defaults, P = 5+2·12·5+5 = 130 cycles.

- `cs_n` low and `busy` high from edge k.
- Bit i (i=0..WORD_W−1, MSB first) is sampled at edge k+CS_SETUP+2·HALF_PERIOD·i, where `sclk` also rises.
- `sclk` falls at edge k+CS_SETUP+2·HALF_PERIOD·i+HALF_PERIOD.
- HOLD is entered at k+CS_SETUP+2·WORD_W·HALF_PERIOD.
- `cs_n` rises, `data_valid` is high for one cycle, and `busy` is low at edge k+P, where P = CS_SETUP+2·WORD_W·HALF_PERIOD+CS_HOLD.
- Next `start` is accepted at edge k+P+1 at the earliest, giving back-to-back transfers with one IDLE cycle (`cs_n` high ≥1 cycle).
- Exactly WORD_W `sclk` rising edges per completed transfer; `sclk` is never high while `cs_n`=1.

## Test plan
- Reset then idle 20 cycles → `cs_n`=1, `sclk`=0, `data_out`=0, `data_valid`=0, `busy`=0 throughout.
- Behavioural slave returns 12'hA5C, `start` pulsed at edge k → 12 `sclk` rises, first at k+5, 10-cycle period; `cs_n` rises and `data_valid` pulses at k+130 with `data_out`=12'hA5C.
- Two back-to-back words, 12'h000 then 12'hFFF, with `start` held high → second `cs_n` fall at k+131; outputs 12'h000 then 12'hFFF; exactly 2 `data_valid` pulses.
- `abort` asserted during bit 6 high phase → next edge `cs_n`=1, `sclk`=0, `busy`=0; `data_out` keeps its previous value; no `data_valid` pulse.
- `rst_n` driven low asynchronously mid-LOW phase, between clock edges → `cs_n`=1, `sclk`=0 without a clock edge; after release, a fresh `start` reads 12'h3C1 correctly.
- Parameter override HALF_PERIOD=1, CS_SETUP=1, CS_HOLD=1, word 12'h801 → completes at k+26 with `data_out`=12'h801.

Source files
------------

// File: rtl/spi_readout_master.sv
// SPI readout master: frames one WORD_W-bit read with cs_n/sclk and shifts sdi in MSB first.
// The captured word is presented on data_out with a one-cycle data_valid strobe.
module spi_readout_master #(
    parameter int WORD_W      = 12,
    parameter int HALF_PERIOD = 5,
    parameter int CS_SETUP    = 5,
    parameter int CS_HOLD     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sdi,
    output logic              cs_n,
    output logic              sclk,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam int BW = $clog2(WORD_W + 1);

    // Terminal counts: each phase ends when the 16-bit counter reaches N-1.
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [BW-1:0] BITS     = BW'(WORD_W);

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_cs_n;
    logic              r_sclk;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    state_t            w_state;
    logic [15:0]       w_cnt;
    logic [BW-1:0]     w_bit_cnt;
    logic [WORD_W-1:0] w_shift;
    logic              w_cs_n;
    logic              w_sclk;
    logic [WORD_W-1:0] w_data;
    logic              w_valid;
    logic              w_busy;

    assign w_busy = (r_state != S_IDLE);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_cs_n    = r_cs_n;
        w_sclk    = r_sclk;
        w_data    = r_data;
        w_valid   = 1'b0;

        // abort outranks every transition but only while a transfer is running,
        // so start+abort in IDLE still launches a transfer.
        if (w_busy && abort) begin
            w_state   = S_IDLE;
            w_cs_n    = 1'b1;
            w_sclk    = 1'b0;
            w_cnt     = '0;
            w_bit_cnt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state   = S_SETUP;
                        w_cs_n    = 1'b0;
                        w_sclk    = 1'b0;
                        w_cnt     = '0;
                        w_bit_cnt = '0;
                        w_shift   = '0;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        w_shift   = {r_shift[WORD_W-2:0], sdi};
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        w_sclk    = 1'b1;
                        w_cnt     = '0;
                        w_state   = S_HIGH;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == HALF_LAST) begin
                        w_sclk  = 1'b0;
                        w_cnt   = '0;
                        w_state = S_LOW;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                S_LOW: begin
                    if (r_cnt == HALF_LAST) begin
                        w_cnt = '0;
                        // sdi is taken on the same edge that raises sclk; the slave
                        // updates it only after that rise.
                        if (r_bit_cnt < BITS) begin
                            w_shift   = {r_shift[WORD_W-2:0], sdi};
                            w_bit_cnt = r_bit_cnt + 1'b1;
                            w_sclk    = 1'b1;
                            w_state   = S_HIGH;
                        end else begin
                            w_state = S_HOLD;
                        end
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_cs_n  = 1'b1;
                        w_data  = r_shift;
                        w_valid = 1'b1;
                        w_cnt   = '0;
                        w_state = S_IDLE;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_cs_n  = 1'b1;
                    w_sclk  = 1'b0;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_cs_n    <= w_cs_n;
            r_sclk    <= w_sclk;
            r_data    <= w_data;
            r_valid   <= w_valid;
        end
    end

    assign cs_n       = r_cs_n;
    assign sclk       = r_sclk;
    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = w_busy;
    assign dbg_state  = r_state;

endmodule
